seq_restoring_divider: RTL and testbench



---
 rtl/seq_restoring_divider.sv | 121 ++++++++++++
 tb/tb_seq_restoring_divider.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one trial subtraction per clock, WIDTH iterations.
// Valid/ready request and result ports; a zero divisor short-circuits straight to DONE.
module seq_restoring_divider #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic [WIDTH-1:0]  r_q, r_d;
    logic [WIDTH-1:0]  d_q, d_d;
    logic [WIDTH-1:0]  quot_q, quot_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic              dbz_q, dbz_d;
    logic [WIDTH:0]    sub_s;
    logic [WIDTH:0]    sub_t;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        d_d     = d_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        sub_s   = {r_q, q_q[WIDTH-1]};
        // MSB of the WIDTH+1-bit difference is the borrow.
        sub_t   = sub_s - {1'b0, d_q};

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    q_d   = dividend;
                    d_d   = divisor;
                    r_d   = '0;
                    cnt_d = '0;
                    if (divisor == '0) begin
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        dbz_d   = 1'b0;
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                if (!sub_t[WIDTH]) begin
                    r_d = sub_t[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    r_d = sub_s[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    quot_d  = q_d;
                    rem_d   = r_d;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            d_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            d_q     <= d_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign in_ready    = (state_q == StIdle);
    assign out_valid   = (state_q == StDone);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: directed cases, mid-op reset and a
// shuffled exhaustive sweep against an arithmetic reference model.
module tb_seq_restoring_divider;

    localparam int unsigned W = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int checks  = 0;
    int errors  = 0;
    int accepts = 0;
    int results = 0;
    int ops     = 0;

    always #5 clk = ~clk;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    // Handshake monitor, independent of the stimulus tasks.
    always @(posedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) accepts++;
            if (out_valid && out_ready) results++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed no finish, expected finish before time limit");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model(input int a, input int b, output int q, output int r,
                                  output int z);
        if (b == 0) begin
            q = (1 << W) - 1;
            r = a;
            z = 1;
        end else begin
            q = a / b;
            r = a % b;
            z = 0;
        end
    endfunction

    task automatic run_op(input int a, input int b, input int stall, input bit keep_valid);
        int eq, er, ez, lat, guard;
        model(a, b, eq, er, ez);
        ops++;
        dividend  = W'(a);
        divisor   = W'(b);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        guard = 0;
        while (!in_ready && guard < 50) begin
            step();
            guard++;
        end
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        step();
        if (!keep_valid) in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 3 * W) begin
            dividend = W'($urandom);
            divisor  = W'($urandom);
            step();
            lat++;
        end
        check("out_valid_rise", 32'(out_valid), 32'd1);
        check("latency", 32'(lat), (b == 0) ? 32'd1 : 32'(W + 1));
        check("quotient", 32'(quotient), 32'(eq));
        check("remainder", 32'(remainder), 32'(er));
        check("div_by_zero", 32'(div_by_zero), 32'(ez));
        if (ez == 0) begin
            check("invariant", 32'((int'(quotient) * b + int'(remainder) == a) &&
                                   (int'(remainder) < b)), 32'd1);
        end
        for (int i = 0; i < stall; i++) begin
            dividend = W'($urandom);
            divisor  = W'($urandom);
            step();
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_quotient", 32'(quotient), 32'(eq));
            check("stall_remainder", 32'(remainder), 32'(er));
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("out_valid_after_handshake", 32'(out_valid), 32'd0);
        check("in_ready_after_handshake", 32'(in_ready), 32'd1);
    endtask

    int order[1024];

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        step();
        step();
        rst = 1'b0;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_quotient", 32'(quotient), 32'd0);
        check("reset_remainder", 32'(remainder), 32'd0);
        check("reset_div_by_zero", 32'(div_by_zero), 32'd0);
        step();
        check("idle_in_ready", 32'(in_ready), 32'd1);

        run_op(23, 4, 0, 1'b0);
        run_op(31, 1, 0, 1'b0);
        run_op(31, 31, 0, 1'b0);
        run_op(3, 9, 0, 1'b0);
        run_op(0, 7, 0, 1'b0);
        run_op(7, 0, 0, 1'b0);
        run_op(10, 3, 0, 1'b0);
        run_op(20, 6, 10, 1'b0);

        // Abort 29/3 in its third CALC cycle.
        dividend = W'(29);
        divisor  = W'(3);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_quotient", 32'(quotient), 32'd0);
        check("midreset_remainder", 32'(remainder), 32'd0);
        check("midreset_in_ready", 32'(in_ready), 32'd1);
        run_op(29, 3, 0, 1'b0);

        for (int i = 0; i < 1024; i++) order[i] = i;
        for (int i = 1023; i > 0; i--) begin
            int j;
            int t;
            j        = int'($urandom_range(i, 0));
            t        = order[i];
            order[i] = order[j];
            order[j] = t;
        end
        for (int i = 0; i < 1024; i++) begin
            run_op(order[i] / 32, order[i] % 32, int'($urandom_range(3, 0)), 1'b1);
        end
        in_valid = 1'b0;
        step();
        step();
        // The aborted 29/3 was accepted but never produced a result.
        check("accept_count", 32'(accepts), 32'(ops + 1));
        check("result_count", 32'(results), 32'(ops));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
